sw_debounce: RTL and testbench
==============================

# sw_debounce

Conditions a raw mechanical switch input for the top-level counter datapath. Synchronises the asynchronous pin, filters contact bounce against a sample tick from `clock_enable`, and produces a clean level, single-cycle press/release/long-press pulses and a press-toggled level. The block sits directly upstream of the counter logic: `sw_toggle` and `sw_rise` replace the in-line toggle register driven from the raw `sw` input.

## Interface
- `SYNC_STAGES`, 2: flip-flop stages in the input synchroniser (≥2).
- `STABLE_TICKS`, 16: consecutive `en` ticks the synchronised input must disagree with `sw_level` before the level changes (≥1).
- `LONG_TICKS`, 100: `en` ticks in the pressed state before `sw_long` fires (≥1).
- `clk`  in  1  system clock.
- `rst`  in  1  reset; one clock; reset is asynchronous and active-low.
- `en`  in  1  sample tick, one-cycle pulse from `clock_enable` (`o_en`).
- `sw`  in  1  raw switch pin, asynchronous to `clk`.
- `sw_level`  out  1  debounced switch level.
- `sw_rise`  out  1  one-cycle pulse on debounced 0→1.
- `sw_fall`  out  1  one-cycle pulse on debounced 1→0.
- `sw_long`  out  1  one-cycle pulse after `LONG_TICKS` ticks held high; once per press.
- `sw_toggle`  out  1  level flipped on every `sw_rise`.

## Operation
- Synchroniser: a shift register of `SYNC_STAGES` stages. All stages reset to 0. `sw_s` is the last stage.
- Four-state FSM:
  - `ST_LOW`: if `sw_s`=1, go to `ST_WAIT_HIGH` and clear `stab_cnt`.
  - `ST_WAIT_HIGH`:
    - `sw_s`=0 (bounce): return to `ST_LOW` and clear `stab_cnt`. This applies regardless of `en`.
    - `en`=1 and `stab_cnt`=`STABLE_TICKS`-1: go to `ST_HIGH`.
    - Otherwise, `en`=1 increments `stab_cnt`.
  - `ST_HIGH`: mirror of `ST_LOW` (`sw_s`=0 → `ST_WAIT_LOW`).
  - `ST_WAIT_LOW`: mirror of `ST_WAIT_HIGH`.
- `sw_level` is 1 in `ST_HIGH` and `ST_WAIT_LOW`, and 0 otherwise. It is registered.
- `stab_cnt` width is `$clog2(STABLE_TICKS+1)`. It never exceeds `STABLE_TICKS`-1.
- Long-press counter `long_cnt`, width `$clog2(LONG_TICKS+1)`:
  - Cleared on entry to `ST_HIGH`.
  - Increments on `en` while in `ST_HIGH` or `ST_WAIT_LOW`.
  - Saturates at `LONG_TICKS`.
  - `sw_long` pulses on the `en` cycle where `long_cnt` goes from `LONG_TICKS`-1 to `LONG_TICKS`.
  - Bounce back to `ST_HIGH` does not clear `long_cnt`. Only a new press clears it.
- `sw_toggle` inverts on the same edge that raises `sw_rise`.

## Timing
- Reset values: all outputs 0, FSM in `ST_LOW`, both counters 0.
- Asynchronous assert; removal is synchronous to `clk` at system level.
- Reset mid-press forces `sw_level`=0 without generating `sw_fall`.
- Latency from a clean pin edge to `sw_level` change:
  - `SYNC_STAGES` cycles to reach `sw_s`.
  - Plus the cycle that enters the WAIT state.
  - Plus the time to accumulate `STABLE_TICKS` `en` ticks.
  - Plus 1 cycle for the output register.
- `sw_rise` and `sw_fall` assert in the same cycle `sw_level` changes, for exactly one cycle.
- `sw_rise`, `sw_fall` and `sw_long` are never asserted in the same cycle. `sw_long` cannot coincide with `sw_fall` because the WAIT_LOW exit and the long-count tick are ordered: if both occur on one `en`, `sw_fall` wins and `sw_long` is suppressed.
- `en` held at 1 continuously is legal. Filtering then counts clock cycles.
- `en`=0 forever holds the FSM in a WAIT state indefinitely. No output changes.

## Structure
- Package `sw_debounce_pkg`:
  - `typedef enum logic [1:0] t_deb_state {ST_LOW, ST_WAIT_HIGH, ST_HIGH, ST_WAIT_LOW}`.
  - Default tick constants.
- Sub-module `sw_sync`: parameterised `SYNC_STAGES` synchroniser with asynchronous active-low reset.
- FSM, counters and output registers live in `sw_debounce`.

## Test plan
All scenarios use `STABLE_TICKS`=4, `LONG_TICKS`=8 and `en` tied to 1 unless stated.
- Reset: assert `rst`=0 mid-operation → all outputs 0 within the same cycle. No pulses after release.
- Clean press: `sw` 0→1 held → `sw_level`, `sw_rise` and `sw_toggle`=1 exactly 2+1+4+1=8 cycles after the edge, with `sw_rise` high for 1 cycle.
- Bounce: `sw` toggles every 2 cycles for 20 cycles, then settles at 1 → no pulses during bouncing. A single `sw_rise` occurs 8 cycles after the final edge.
- Long press: hold `sw`=1 for 30 cycles → `sw_long` pulses once, 8 ticks after entering `ST_HIGH`. Release → one `sw_fall`. Second press → `sw_toggle` returns to 0.
- Sparse tick: `en` every 10th cycle, with a press held for 35 cycles → no `sw_rise`. Held for 60 cycles → one `sw_rise`.
- Glitch: 1-cycle `sw` pulse (< one tick) → `sw_level` stays 0, no pulses, FSM back in `ST_LOW`.

Source files
------------

// File: rtl/sw_debounce_pkg.sv
// Shared types and default tick constants for the switch debouncer.
package sw_debounce_pkg;

  typedef enum logic [1:0] {
    ST_LOW       = 2'd0,
    ST_WAIT_HIGH = 2'd1,
    ST_HIGH      = 2'd2,
    ST_WAIT_LOW  = 2'd3
  } t_deb_state;

  localparam int unsigned DEF_SYNC_STAGES  = 2;
  localparam int unsigned DEF_STABLE_TICKS = 16;
  localparam int unsigned DEF_LONG_TICKS   = 100;

endpackage

// File: rtl/sw_debounce_sync.sv
// Multi-stage flip-flop synchroniser for an asynchronous single-bit input.
module sw_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic sync_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
    end
  end

  assign sync_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/sw_debounce.sv
// Switch conditioner: synchronise, debounce against a sample tick, and derive
// edge, long-press and toggle outputs for the downstream counter logic.
module sw_debounce
  import sw_debounce_pkg::*;
#(
  parameter int unsigned SYNC_STAGES  = DEF_SYNC_STAGES,
  parameter int unsigned STABLE_TICKS = DEF_STABLE_TICKS,
  parameter int unsigned LONG_TICKS   = DEF_LONG_TICKS
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic sw,
  output logic sw_level,
  output logic sw_rise,
  output logic sw_fall,
  output logic sw_long,
  output logic sw_toggle
);

  localparam int unsigned STAB_W = $clog2(STABLE_TICKS + 1);
  localparam int unsigned LONG_W = $clog2(LONG_TICKS + 1);

  logic              sw_s;
  t_deb_state        state_q, state_d;
  logic [STAB_W-1:0] stab_cnt_q, stab_cnt_d;
  logic [LONG_W-1:0] long_cnt_q, long_cnt_d;
  logic              sw_level_q, sw_level_d;
  logic              sw_rise_q, sw_rise_d;
  logic              sw_fall_q, sw_fall_d;
  logic              sw_long_q, sw_long_d;
  logic              sw_toggle_q, sw_toggle_d;
  logic              stab_done;
  logic              in_press;
  logic              leaving;

  sw_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .rst_n  (rst),
    .async_i(sw),
    .sync_o (sw_s)
  );

  // Next-state, counters and output pulses
  always_comb begin
    state_d    = state_q;
    stab_cnt_d = stab_cnt_q;
    long_cnt_d = long_cnt_q;
    sw_long_d  = 1'b0;
    stab_done  = en && (stab_cnt_q == STAB_W'(STABLE_TICKS - 1));

    case (state_q)
      ST_LOW: begin
        if (sw_s) begin
          state_d    = ST_WAIT_HIGH;
          stab_cnt_d = '0;
        end
      end
      ST_WAIT_HIGH: begin
        if (!sw_s) begin
          state_d    = ST_LOW;
          stab_cnt_d = '0;
        end else if (stab_done) begin
          state_d    = ST_HIGH;
          stab_cnt_d = '0;
          long_cnt_d = '0;
        end else if (en) begin
          stab_cnt_d = stab_cnt_q + STAB_W'(1);
        end
      end
      ST_HIGH: begin
        if (!sw_s) begin
          state_d    = ST_WAIT_LOW;
          stab_cnt_d = '0;
        end
      end
      ST_WAIT_LOW: begin
        if (sw_s) begin
          state_d    = ST_HIGH;
          stab_cnt_d = '0;
        end else if (stab_done) begin
          state_d    = ST_LOW;
          stab_cnt_d = '0;
        end else if (en) begin
          stab_cnt_d = stab_cnt_q + STAB_W'(1);
        end
      end
      default: begin
        state_d    = ST_LOW;
        stab_cnt_d = '0;
      end
    endcase

    // A release that completes on this tick takes priority over the long count
    in_press = (state_q == ST_HIGH) || (state_q == ST_WAIT_LOW);
    leaving  = (state_q == ST_WAIT_LOW) && (state_d == ST_LOW);
    if (in_press && en && !leaving && (long_cnt_q != LONG_W'(LONG_TICKS))) begin
      long_cnt_d = long_cnt_q + LONG_W'(1);
      sw_long_d  = (long_cnt_q == LONG_W'(LONG_TICKS - 1));
    end

    sw_level_d  = in_press;
    sw_rise_d   = sw_level_d && !sw_level_q;
    sw_fall_d   = !sw_level_d && sw_level_q;
    sw_toggle_d = sw_toggle_q ^ sw_rise_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_LOW;
      stab_cnt_q  <= '0;
      long_cnt_q  <= '0;
      sw_level_q  <= 1'b0;
      sw_rise_q   <= 1'b0;
      sw_fall_q   <= 1'b0;
      sw_long_q   <= 1'b0;
      sw_toggle_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      stab_cnt_q  <= stab_cnt_d;
      long_cnt_q  <= long_cnt_d;
      sw_level_q  <= sw_level_d;
      sw_rise_q   <= sw_rise_d;
      sw_fall_q   <= sw_fall_d;
      sw_long_q   <= sw_long_d;
      sw_toggle_q <= sw_toggle_d;
    end
  end

  assign sw_level  = sw_level_q;
  assign sw_rise   = sw_rise_q;
  assign sw_fall   = sw_fall_q;
  assign sw_long   = sw_long_q;
  assign sw_toggle = sw_toggle_q;

endmodule

// File: tb/tb_sw_debounce.sv
// Cycle-accurate scoreboard bench for sw_debounce with STABLE_TICKS=4, LONG_TICKS=8.
module tb_sw_debounce;
  import sw_debounce_pkg::*;

  localparam logic [2:0] P_RISE = 3'b001;
  localparam logic [2:0] P_FALL = 3'b010;
  localparam logic [2:0] P_LONG = 3'b100;

  typedef struct {
    int         cyc;
    logic [2:0] pulses;
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  logic en = 1'b1;
  logic sw;
  logic sw_level, sw_rise, sw_fall, sw_long, sw_toggle;

  int   cyc     = 0;
  int   en_mode = 0;
  int   checks  = 0;
  int   errors  = 0;
  logic exp_level  = 1'b0;
  logic exp_toggle = 1'b0;
  ev_t  exp_q[$];

  sw_debounce #(
    .SYNC_STAGES (2),
    .STABLE_TICKS(4),
    .LONG_TICKS  (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .sw       (sw),
    .sw_level (sw_level),
    .sw_rise  (sw_rise),
    .sw_fall  (sw_fall),
    .sw_long  (sw_long),
    .sw_toggle(sw_toggle)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // en_mode 0: tick every cycle, 1: tick on every posedge where cyc becomes a multiple of 10, 2: no ticks
  always @(negedge clk) begin
    if (en_mode == 0)      en = 1'b1;
    else if (en_mode == 1) en = ((cyc + 1) % 10 == 0);
    else                   en = 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h cyc=%0d", tag, obs, expv, cyc);
    end
  endtask

  task automatic push(input int delay, input logic [2:0] p);
    ev_t ev;
    ev.cyc    = cyc + delay;
    ev.pulses = p;
    exp_q.push_back(ev);
  endtask

  // One cycle: pop any event due now, then compare pulses, level and toggle
  task automatic sample();
    ev_t        ev;
    logic [2:0] obs;
    logic [2:0] expp;
    @(negedge clk);
    obs  = {sw_long, sw_fall, sw_rise};
    expp = 3'b000;
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      ev   = exp_q.pop_front();
      expp = ev.pulses;
      if (expp[0]) begin
        exp_level  = 1'b1;
        exp_toggle = ~exp_toggle;
      end
      if (expp[1]) exp_level = 1'b0;
    end
    check("pulses", 32'(obs), 32'(expp));
    check("level", 32'(sw_level), 32'(exp_level));
    check("toggle", 32'(sw_toggle), 32'(exp_toggle));
    check("exclusive", 32'($onehot0(obs)), 32'd1);
  endtask

  task automatic run(input int n);
    repeat (n) sample();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_level"}, 32'(sw_level), 32'd0);
    check({tag, "_rise"}, 32'(sw_rise), 32'd0);
    check({tag, "_fall"}, 32'(sw_fall), 32'd0);
    check({tag, "_long"}, 32'(sw_long), 32'd0);
    check({tag, "_toggle"}, 32'(sw_toggle), 32'd0);
  endtask

  initial begin
    rst = 1'b0;
    sw  = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    check("reset_state", 32'(dut.state_q), 32'(ST_LOW));
    rst = 1'b1;
    run(5);

    // Clean press held long enough for a long-press, then release
    sw = 1'b1;
    push(8, P_RISE);
    push(15, P_LONG);
    run(30);
    sw = 1'b0;
    push(8, P_FALL);
    run(15);

    // Second press returns the toggle to 0
    sw = 1'b1;
    push(8, P_RISE);
    push(15, P_LONG);
    run(20);
    check("toggle_back", 32'(sw_toggle), 32'd0);
    sw = 1'b0;
    push(8, P_FALL);
    run(12);

    // Bounce every 2 cycles for 20 cycles, then settle high
    for (int i = 0; i < 10; i++) begin
      sw = (i % 2 == 0);
      run(2);
    end
    sw = 1'b1;
    push(8, P_RISE);
    push(15, P_LONG);
    run(20);
    sw = 1'b0;
    push(8, P_FALL);
    run(12);

    // Single-cycle glitch
    sw = 1'b1;
    run(1);
    sw = 1'b0;
    run(10);
    check("glitch_state", 32'(dut.state_q), 32'(ST_LOW));

    // No ticks: FSM parks in WAIT_HIGH, nothing changes
    en_mode = 2;
    run(1);
    sw = 1'b1;
    run(40);
    check("hold_wait", 32'(dut.state_q), 32'(ST_WAIT_HIGH));
    sw = 1'b0;
    run(6);
    check("hold_release", 32'(dut.state_q), 32'(ST_LOW));

    // Sparse ticks: 35-cycle press too short, 60-cycle press accepted
    en_mode = 1;
    run(1);
    for (int i = 0; i < 10 && (cyc % 10 != 0); i++) run(1);
    sw = 1'b1;
    run(35);
    sw = 1'b0;
    run(15);
    for (int i = 0; i < 10 && (cyc % 10 != 0); i++) run(1);
    sw = 1'b1;
    push(41, P_RISE);
    run(60);
    sw = 1'b0;
    push(41, P_FALL);
    run(50);

    // Reset mid-press clears everything and produces no fall afterwards
    en_mode = 0;
    run(1);
    sw = 1'b1;
    push(8, P_RISE);
    push(15, P_LONG);
    run(10);
    rst = 1'b0;
    #1;
    check_all_zero("midreset");
    exp_q.delete();
    exp_level  = 1'b0;
    exp_toggle = 1'b0;
    sw = 1'b0;
    run(2);
    rst = 1'b1;
    run(20);

    check("drain", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
